// File: rtl/rx_pkg.sv
// Shared constants and types for the serial-to-parallel word receiver.
package rx_pkg;

  localparam int   DEFAULT_WORD_BITS = 8;
  localparam logic SHIFT_MSB_FIRST   = 1'b1;
  localparam logic SHIFT_LSB_FIRST   = 1'b0;

  // Occupancy of the output holding register.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/stp_word_rx_if.sv
// Serial input and parallel output handshake bundle of the word receiver.
interface stp_word_rx_if
  import rx_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_WORD_BITS
) ();

  localparam int CW = $clog2(NUM_BITS + 1);

  logic                shift_enable;
  logic                serial_in;
  logic                clear;
  logic                out_ready;
  logic [NUM_BITS-1:0] parallel_out;
  logic                out_valid;
  logic                overrun;
  logic [CW-1:0]       bit_count;

  // Producer of serial bits and consumer of parallel words.
  modport master (
    output shift_enable, serial_in, clear, out_ready,
    input  parallel_out, out_valid, overrun, bit_count
  );

  // The receiver itself.
  modport slave (
    input  shift_enable, serial_in, clear, out_ready,
    output parallel_out, out_valid, overrun, bit_count
  );

endinterface

// File: rtl/flex_stp_sr.sv
// Flexible serial-to-parallel shift register; idles at all ones.
module flex_stp_sr
  import rx_pkg::*;
#(
  parameter int   NUM_BITS  = DEFAULT_WORD_BITS,
  parameter logic SHIFT_MSB = SHIFT_MSB_FIRST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  input  logic                clear,
  output logic [NUM_BITS-1:0] parallel
);

  logic [NUM_BITS-1:0] shifted;

  generate
    if (SHIFT_MSB) begin : g_msb
      assign shifted = {parallel[NUM_BITS-2:0], serial_in};
    end else begin : g_lsb
      assign shifted = {serial_in, parallel[NUM_BITS-1:1]};
    end
  endgenerate

  // Reset and clear both return to all ones; clear beats a same-cycle shift.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      parallel <= '1;
    end else if (shift_enable) begin
      parallel <= shifted;
    end
  end

endmodule

// File: rtl/stp_word_rx.sv
// Word receiver: bit counter, completion detect, holding register and handshake.
module stp_word_rx
  import rx_pkg::*;
#(
  parameter int   NUM_BITS  = DEFAULT_WORD_BITS,
  parameter logic SHIFT_MSB = SHIFT_MSB_FIRST
) (
  input logic          clk,
  input logic          rst,
  stp_word_rx_if.slave bus
);

  localparam int            CW       = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

  logic [NUM_BITS-1:0] sr_word;
  logic [NUM_BITS-1:0] word_done;
  logic [NUM_BITS-1:0] hold_word;
  logic [CW-1:0]       bit_count;
  logic                overrun;
  logic                sample;
  logic                complete;
  logic                load;
  logic                drop;
  hold_state_e         state;
  hold_state_e         state_next;

  flex_stp_sr #(
    .NUM_BITS  (NUM_BITS),
    .SHIFT_MSB (SHIFT_MSB)
  ) u_sr (
    .clk          (clk),
    .rst          (rst),
    .shift_enable (bus.shift_enable),
    .serial_in    (bus.serial_in),
    .clear        (bus.clear),
    .parallel     (sr_word)
  );

  // The completed word is what the shift register is about to become.
  generate
    if (SHIFT_MSB) begin : g_done_msb
      assign word_done = {sr_word[NUM_BITS-2:0], bus.serial_in};
    end else begin : g_done_lsb
      assign word_done = {bus.serial_in, sr_word[NUM_BITS-1:1]};
    end
  endgenerate

  assign sample   = bus.shift_enable && !bus.clear;
  assign complete = sample && (bit_count == LAST_BIT);

  // Bit counter runs 0..NUM_BITS-1 and wraps on the completing sample.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      bit_count <= '0;
    end else if (sample) begin
      bit_count <= complete ? '0 : bit_count + CW'(1);
    end
  end

  // Holding register occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HOLD_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Decide whether a completed word is loaded, dropped, or the slot drains.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      HOLD_EMPTY: begin
        if (complete) begin
          load       = 1'b1;
          state_next = HOLD_FULL;
        end
      end
      HOLD_FULL: begin
        if (complete) begin
          if (bus.out_ready) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (bus.out_ready) begin
          state_next = HOLD_EMPTY;
        end
      end
      default: state_next = HOLD_EMPTY;
    endcase
  end

  // Holding register keeps the last accepted word until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_word <= '1;
    end else if (load) begin
      hold_word <= word_done;
    end
  end

  // Sticky overrun flag, set when a completed word finds the slot occupied.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

  assign bus.parallel_out = hold_word;
  assign bus.out_valid    = (state == HOLD_FULL);
  assign bus.overrun      = overrun;
  assign bus.bit_count    = bit_count;

endmodule
